i2s_rx_stereo_master: RTL and testbench

- Parametrised stereo I2S master receiver for the microphone path.
- Generates the I2S bit clock (SCK) and word select (WS) from the system clock.
- Captures Philips-format serial data, MSB first, with a one-SCK delay after each WS edge.
- Delivers left/right sample pairs to downstream logic through a valid/ready handshake with sticky overrun detection.

---
 rtl/i2s_rx_stereo_master.sv | 176 +++++++++++++++++
 tb/tb_i2s_rx_stereo_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stereo_master.sv
// Stereo I2S master receiver: generates SCK/WS, captures Philips-format data
// and hands left/right pairs downstream over valid/ready with sticky overrun.
//
// state      | meaning
// ST_EMPTY   | no pair held, valid=0
// ST_HOLD    | pair held in left_data/right_data, valid=1
module i2s_rx_stereo_master #(
    parameter int DATA_SIZE = 24,
    parameter int SLOT_SIZE = 32,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 i2s_sd,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic [DATA_SIZE-1:0] left_data,
    output logic [DATA_SIZE-1:0] right_data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = (SLOT_SIZE > 1) ? $clog2(SLOT_SIZE) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_SIZE - 1);
    localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(DATA_SIZE - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]     div_cnt;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [SLOT_W-1:0]    pos_q;
    logic                 ws_q;
    logic                 armed;
    logic                 tick;
    logic                 rise;
    logic                 fall;
    logic [DATA_SIZE-2:0] shift_reg;
    logic [DATA_SIZE-1:0] word_in;
    logic [DATA_SIZE-1:0] left_stage;
    logic [DATA_SIZE-1:0] right_stage;
    logic                 left_got;
    logic                 pair_pend;
    logic                 load;
    logic                 drop;

    assign tick    = enable && (div_cnt == DIV_LAST);
    assign rise    = tick && !i2s_sck;
    assign fall    = tick && i2s_sck;
    assign word_in = {shift_reg, i2s_sd};
    assign valid   = (state == ST_HOLD);

    // Bit clock and word select; pos_q/ws_q hold the pre-fall slot position so
    // the last bit of a slot, sampled after WS has flipped, lands in the right word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_sck  <= 1'b0;
            i2s_ws   <= 1'b0;
            slot_cnt <= '0;
            pos_q    <= '0;
            ws_q     <= 1'b0;
            armed    <= 1'b0;
        end else if (!enable) begin
            div_cnt  <= '0;
            i2s_sck  <= 1'b0;
            i2s_ws   <= 1'b0;
            slot_cnt <= '0;
            pos_q    <= '0;
            ws_q     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                i2s_sck <= ~i2s_sck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall) begin
                pos_q <= slot_cnt;
                ws_q  <= i2s_ws;
                armed <= 1'b1;
                if (slot_cnt == SLOT_LAST) begin
                    slot_cnt <= '0;
                    i2s_ws   <= ~i2s_ws;
                end else begin
                    slot_cnt <= slot_cnt + SLOT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            left_stage  <= '0;
            right_stage <= '0;
            left_got    <= 1'b0;
            pair_pend   <= 1'b0;
        end else begin
            pair_pend <= 1'b0;
            if (!enable) begin
                shift_reg <= '0;
                left_got  <= 1'b0;
            end else if (rise && armed && (pos_q <= DATA_LAST)) begin
                shift_reg <= word_in[DATA_SIZE-2:0];
                if (pos_q == DATA_LAST) begin
                    if (!ws_q) begin
                        left_stage <= word_in;
                        left_got   <= 1'b1;
                    end else if (left_got) begin
                        right_stage <= word_in;
                        pair_pend   <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (pair_pend) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pair_pend) begin
                    if (ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            left_data  <= '0;
            right_data <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                left_data  <= left_stage;
                right_data <= right_stage;
            end
            // a drop on the same edge as a clear request keeps the flag set
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_stereo_master.sv
// Bench for i2s_rx_stereo_master: microphone models feed two configurations,
// completed pairs are queued and compared when the DUT hands them over.
module tb_i2s_rx_stereo_master;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    typedef struct {
        int          cnt;
        logic        last_ws;
        logic        left_full;
        logic        sd;
        logic        push;
        logic [31:0] lsent;
        pair_t       pair;
    } mic_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, clr;
    logic en24, rdy24, sd24, sck24, ws24, valid24, ovr24;
    logic [23:0] left24, right24;
    logic en16, rdy16, sd16, sck16, ws16, valid16, ovr16;
    logic [15:0] left16, right16;
    logic [31:0] l24, r24, l16, r16;

    pair_t q24[$];
    pair_t q16[$];
    mic_t  m24, m16;
    logic  sck24_q, sck16_q;

    int checks = 0;
    int failures = 0;

    i2s_rx_stereo_master u_dut24 (
        .clk(clk), .rst_n(rst_n), .enable(en24), .i2s_sd(sd24),
        .i2s_sck(sck24), .i2s_ws(ws24), .left_data(left24), .right_data(right24),
        .valid(valid24), .ready(rdy24), .overrun(ovr24), .clear_overrun(clr)
    );

    i2s_rx_stereo_master #(.DATA_SIZE(16), .SLOT_SIZE(16), .CLK_DIV(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .enable(en16), .i2s_sd(sd16),
        .i2s_sck(sck16), .i2s_ws(ws16), .left_data(left16), .right_data(right16),
        .valid(valid16), .ready(rdy16), .overrun(ovr16), .clear_overrun(clr)
    );

    // One SCK fall of the microphone: a WS change sends the previous slot's
    // last bit, otherwise bit (falls since the WS change - 1) of the current slot.
    function automatic mic_t mic_step(mic_t s, logic ws, int data_n, int slot_n,
                                      logic [31:0] lw, logic [31:0] rw);
        mic_t n;
        int   idx;
        logic ch;
        n = s;
        n.push = 1'b0;
        if (ws != s.last_ws) begin
            idx       = slot_n - 1;
            ch        = s.last_ws;
            n.cnt     = 0;
            n.last_ws = ws;
        end else begin
            n.cnt = s.cnt + 1;
            idx   = n.cnt - 1;
            ch    = ws;
        end
        n.sd = 1'b0;
        if (idx < data_n) begin
            n.sd = ch ? rw[data_n-1-idx] : lw[data_n-1-idx];
            if (idx == data_n - 1) begin
                if (!ch) begin
                    n.left_full = 1'b1;
                    n.lsent     = lw;
                end else if (s.left_full) begin
                    n.push   = 1'b1;
                    n.pair.l = s.lsent;
                    n.pair.r = rw;
                end
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !en24) begin
            m24 = '{default: 0};
            sck24_q = 1'b0;
            sd24 = 1'b0;
        end else begin
            if (sck24_q && !sck24) begin
                m24 = mic_step(m24, ws24, 24, 32, l24, r24);
                sd24 = m24.sd;
                if (m24.push) q24.push_back(m24.pair);
            end
            sck24_q = sck24;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || !en16) begin
            m16 = '{default: 0};
            sck16_q = 1'b0;
            sd16 = 1'b0;
        end else begin
            if (sck16_q && !sck16) begin
                m16 = mic_step(m16, ws16, 16, 16, l16, r16);
                sd16 = m16.sd;
                if (m16.push) q16.push_back(m16.pair);
            end
            sck16_q = sck16;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return valid24;
            1:       return ws24;
            default: return ovr24;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic val, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig(sel) === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    // Wait for an accept (valid && ready before the next edge), compare the
    // held pair against the oldest queued pair, then step past the accept edge.
    task automatic expect24(input string tag, input int budget, output int at);
        bit    got;
        pair_t e;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid24 && rdy24) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        at = cyc;
        chk({tag, "_seen"}, 64'(got), 64'(1));
        if (got) begin
            e = (q24.size() > 0) ? q24.pop_front() : '{l: 32'hFFFF_FFFF, r: 32'hFFFF_FFFF};
            chk({tag, "_pair"}, 64'({left24, right24}), 64'({e.l[23:0], e.r[23:0]}));
            @(negedge clk);
        end
    endtask

    task automatic expect16(input string tag, input int budget, output int at);
        bit    got;
        pair_t e;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid16 && rdy16) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        at = cyc;
        chk({tag, "_seen"}, 64'(got), 64'(1));
        if (got) begin
            e = (q16.size() > 0) ? q16.pop_front() : '{l: 32'hFFFF_FFFF, r: 32'hFFFF_FFFF};
            chk({tag, "_pair"}, 64'({left16, right16}), 64'({e.l[15:0], e.r[15:0]}));
            @(negedge clk);
        end
    endtask

    task automatic find_edge(input bit use_ws, input int budget, output int at);
        logic prev, cur;
        at = -1;
        prev = use_ws ? ws24 : sck24;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = use_ws ? ws24 : sck24;
            if (use_ws ? (cur != prev) : (!prev && cur)) begin
                at = cyc;
                break;
            end
            prev = cur;
        end
    endtask

    function automatic logic [47:0] head24();
        return (q24.size() > 0) ? {q24[0].l[23:0], q24[0].r[23:0]} : 48'hFFFF_FFFF_FFFF;
    endfunction

    initial begin
        int c0, t1, t2, a, b, k;
        bit idle_bad;
        rst_n = 1'b0; clr = 1'b0;
        en24 = 1'b0; rdy24 = 1'b0; en16 = 1'b0; rdy16 = 1'b0;
        l24 = 32'hA5A5A5; r24 = 32'h5A5A5A;
        l16 = 32'h8001;   r16 = 32'h7FFE;
        repeat (3) @(negedge clk);
        chk("rst_sck", 64'(sck24), 64'(0));
        chk("rst_ws", 64'(ws24), 64'(0));
        chk("rst_valid", 64'(valid24), 64'(0));
        chk("rst_overrun", 64'(ovr24), 64'(0));
        chk("rst_data", 64'({left24, right24}), 64'(0));
        chk("rst_valid16", 64'(valid16), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 16/16 slot, CLK_DIV=1: right LSB arrives after WS returns low
        c0 = cyc; en16 = 1'b1; rdy16 = 1'b1;
        expect16("p16_first", 150, t1);
        chk("p16_latency", 64'(t1 - c0), 64'(66));
        expect16("p16_second", 100, t2);
        chk("p16_frame", 64'(t2 - t1), 64'(64));
        en16 = 1'b0;
        repeat (2) @(negedge clk);
        chk("p16_idle_sck", 64'({sck16, ws16}), 64'(0));

        // defaults, continuous ready
        c0 = cyc; en24 = 1'b1; rdy24 = 1'b1;
        expect24("p24_first", 300, t1);
        chk("p24_latency", 64'(t1 - c0), 64'(227));
        chk("valid_pulse", 64'(valid24), 64'(0));
        find_edge(1'b0, 20, a);
        find_edge(1'b0, 20, b);
        chk("sck_period", 64'(b - a), 64'(4));
        find_edge(1'b1, 200, a);
        find_edge(1'b1, 200, b);
        chk("ws_half", 64'(b - a), 64'(128));
        expect24("p24_second", 300, t2);
        chk("frame_period", 64'(t2 - t1), 64'(256));

        // back-pressure: first pair held, second dropped
        rdy24 = 1'b0;
        wait_sig("hold_wait", 0, 1'b1, 300);
        chk("hold_pair", 64'({left24, right24}), 64'(head24()));
        l24 = 32'h123456; r24 = 32'h654321;
        wait_sig("ovr_wait", 2, 1'b1, 300);
        k = cyc;
        chk("ovr_valid", 64'(valid24), 64'(1));
        chk("ovr_pair_kept", 64'({left24, right24}), 64'(head24()));
        if (q24.size() > 1) q24.delete(1);
        l24 = 32'hABCDEF; r24 = 32'h0F0F0F;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovr_cleared", 64'(ovr24), 64'(0));
        chk("clr_valid", 64'(valid24), 64'(1));
        chk("clr_pair_kept", 64'({left24, right24}), 64'(head24()));

        // ready raised exactly on the next completion edge
        for (int i = 0; i < 300; i++) begin
            if (cyc == k + 255) break;
            @(negedge clk);
        end
        chk("edge_align", 64'(cyc), 64'(k + 255));
        rdy24 = 1'b1;
        expect24("p1_accept", 1, t1);
        rdy24 = 1'b0;
        chk("swap_valid", 64'(valid24), 64'(1));
        chk("swap_pair", 64'({left24, right24}), 64'(head24()));
        chk("swap_overrun", 64'(ovr24), 64'(0));
        rdy24 = 1'b1;
        expect24("p3_accept", 1, t1);

        // disable during the right slot, then re-enable
        wait_sig("ws_low", 1, 1'b0, 100);
        wait_sig("ws_high", 1, 1'b1, 200);
        repeat (20) @(negedge clk);
        en24 = 1'b0;
        repeat (2) @(negedge clk);
        idle_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sck24 !== 1'b0 || ws24 !== 1'b0 || valid24 !== 1'b0) idle_bad = 1'b1;
            @(negedge clk);
        end
        chk("dis_idle", 64'(idle_bad), 64'(0));
        c0 = cyc; en24 = 1'b1;
        expect24("reen_first", 400, t1);
        chk("reen_latency", 64'(t1 - c0), 64'(227));

        // reset during left bit 10 with a pair held
        rdy24 = 1'b0;
        wait_sig("pre_rst_valid", 0, 1'b1, 300);
        wait_sig("pre_rst_ws", 1, 1'b0, 100);
        repeat (44) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sck_ws", 64'({sck24, ws24}), 64'(0));
        chk("mid_rst_valid", 64'(valid24), 64'(0));
        chk("mid_rst_overrun", 64'(ovr24), 64'(0));
        chk("mid_rst_data", 64'({left24, right24}), 64'(0));
        q24.delete();
        @(negedge clk);
        rdy24 = 1'b1;
        c0 = cyc; rst_n = 1'b1;
        expect24("post_rst_first", 400, t1);
        chk("post_rst_latency", 64'(t1 - c0), 64'(227));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
